// File: rtl/matrix_scan_controller.sv
// 5x7 LED matrix column scanner time-sharing page A and optional page B, with a blank frame at each page switch.
// Optional dead time on column changes: define MATRIX_SCAN_DEADTIME_EN.
module matrix_scan_controller #(
  parameter int SCAN_DIV    = 1000,
  parameter int PAGE_FRAMES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] img_a_col_1,
  input  logic [6:0] img_a_col_0,
  input  logic [6:0] img_b_col_1,
  input  logic [6:0] img_b_col_0,
  input  logic       img_b_valid,
  output logic [4:0] col_en,
  output logic [6:0] row_data,
  output logic       page,
  output logic       frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  localparam logic [1:0] SHOW_A   = 2'd0;
  localparam logic [1:0] BLANK_AB = 2'd1;
  localparam logic [1:0] SHOW_B   = 2'd2;
  localparam logic [1:0] BLANK_BA = 2'd3;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       col_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic [FRM_W-1:0] frame_cnt_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [6:0]       buf_col_1;
  logic [6:0]       buf_col_0;

  logic slot_end;
  logic frame_end;
  logic frame_last;
  logic blank;
  logic dead;

  assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end  = slot_end && (col_idx == 3'd4);
  assign frame_last = (frame_cnt == FRM_W'(PAGE_FRAMES - 1));
  assign blank      = (state == BLANK_AB) || (state == BLANK_BA);

`ifdef MATRIX_SCAN_DEADTIME_EN
  // Hold the column off for the first two clocks of each slot to kill ghosting.
  assign dead = (div_cnt < DIV_W'(2));
`else
  assign dead = 1'b0;
`endif

  // Page sequencing is evaluated only at frame boundaries.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    case (state)
      SHOW_A: begin
        if (frame_last) begin
          frame_cnt_nxt = '0;
          if (img_b_valid) state_nxt = BLANK_AB;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      BLANK_AB: begin
        frame_cnt_nxt = '0;
        state_nxt     = SHOW_B;
      end
      SHOW_B: begin
        if (frame_last || !img_b_valid) begin
          frame_cnt_nxt = '0;
          state_nxt     = BLANK_BA;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      default: begin
        frame_cnt_nxt = '0;
        state_nxt     = SHOW_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      col_idx   <= 3'd0;
      frame_cnt <= '0;
      state     <= SHOW_A;
      buf_col_1 <= 7'd0;
      buf_col_0 <= 7'd0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) col_idx <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
      if (frame_end) begin
        state     <= state_nxt;
        frame_cnt <= frame_cnt_nxt;
        // Latch the image of the page about to be shown so mid-frame input changes never tear it.
        if (state_nxt == SHOW_B) begin
          buf_col_1 <= img_b_col_1;
          buf_col_0 <= img_b_col_0;
        end else begin
          buf_col_1 <= img_a_col_1;
          buf_col_0 <= img_a_col_0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_en     <= 5'd0;
      row_data   <= 7'd0;
      page       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      page       <= (state == SHOW_B);
      if (blank) begin
        col_en   <= 5'd0;
        row_data <= 7'd0;
      end else begin
        col_en   <= dead ? 5'd0 : (5'b00001 << col_idx);
        row_data <= ((col_idx == 3'd0) || (col_idx == 3'd4)) ? buf_col_1 : buf_col_0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: directed test-plan checks plus randomized stimulus against a frame-level reference model.
module tb_matrix_scan_controller;

  localparam int SD = 4;
  localparam int PF = 2;
  localparam int FRAME_CLKS = 5 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] img_a_col_1 = 7'd0;
  logic [6:0] img_a_col_0 = 7'd0;
  logic [6:0] img_b_col_1 = 7'd0;
  logic [6:0] img_b_col_0 = 7'd0;
  logic       img_b_valid = 1'b0;
  logic [4:0] col_en;
  logic [6:0] row_data;
  logic       page;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  matrix_scan_controller #(.SCAN_DIV(SD), .PAGE_FRAMES(PF)) dut (
    .clk(clk), .reset(reset),
    .img_a_col_1(img_a_col_1), .img_a_col_0(img_a_col_0),
    .img_b_col_1(img_b_col_1), .img_b_col_0(img_b_col_0),
    .img_b_valid(img_b_valid),
    .col_en(col_en), .row_data(row_data), .page(page), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position derived from clocks elapsed in the frame; a schedule of frame kinds
  // (0 = A, 1 = blank before B, 2 = B, 3 = blank before A) decided once per frame.
  int         m_t, m_kind, m_shown;
  logic [6:0] m_b1, m_b0;
  logic [4:0] e_col;
  logic [6:0] e_row;
  logic       e_page, e_tick;

  always @(posedge clk) begin
    int col, ph;
    if (reset) begin
      m_t = 0; m_kind = 0; m_shown = 0; m_b1 = 0; m_b0 = 0;
      e_col = 0; e_row = 0; e_page = 0; e_tick = 0;
    end else begin
      col = m_t / SD;
      ph  = m_t % SD;
      if (m_kind == 1 || m_kind == 3) begin
        e_col = 0; e_row = 0;
      end else begin
        e_col = 5'(1 << col);
`ifdef MATRIX_SCAN_DEADTIME_EN
        if (ph < 2) e_col = 0;
`endif
        e_row = (col == 0 || col == 4) ? m_b1 : m_b0;
      end
      e_page = (m_kind == 2);
      e_tick = (m_t == FRAME_CLKS - 1);
      if (m_t == FRAME_CLKS - 1) begin
        if (m_kind == 0 || m_kind == 2) m_shown++;
        if (m_kind == 0 && m_shown >= PF) begin
          m_shown = 0;
          if (img_b_valid) m_kind = 1;
        end else if (m_kind == 2 && (m_shown >= PF || !img_b_valid)) begin
          m_shown = 0; m_kind = 3;
        end else if (m_kind == 1) begin
          m_kind = 2;
        end else if (m_kind == 3) begin
          m_kind = 0;
        end
        m_b1 = (m_kind == 2) ? img_b_col_1 : img_a_col_1;
        m_b0 = (m_kind == 2) ? img_b_col_0 : img_a_col_0;
      end
      m_t = (m_t + 1) % FRAME_CLKS;
    end
  end

  task automatic test_reset();
    int tick_at;
    logic [4:0] first_col;
`ifdef MATRIX_SCAN_DEADTIME_EN
    first_col = 5'b00000;
`else
    first_col = 5'b00001;
`endif
    img_a_col_1 = 7'h41; img_a_col_0 = 7'h7F; img_b_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (col_en !== 5'd0) begin errors++; $display("FAIL reset_col_en got %b exp 00000", col_en); end
    checks++; if (row_data !== 7'd0) begin errors++; $display("FAIL reset_row got %h exp 00", row_data); end
    checks++; if (page !== 1'b0) begin errors++; $display("FAIL reset_page got %b exp 0", page); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    reset = 1'b0;
    tick_at = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (col_en !== first_col) begin errors++; $display("FAIL first_col got %b exp %b", col_en, first_col); end
      end
      if (k == 7) begin
        checks++; if (col_en !== 5'b00010) begin errors++; $display("FAIL walk_col1 got %b exp 00010", col_en); end
      end
      if (k == 19) begin
        checks++; if (col_en !== 5'b10000) begin errors++; $display("FAIL walk_col4 got %b exp 10000", col_en); end
      end
      if (k <= 20 && row_data !== 7'd0) begin
        checks++; errors++; $display("FAIL frame1_row k=%0d got %h exp 00", k, row_data);
      end
      if (k == 23) begin
        checks++; if (row_data !== 7'h41) begin errors++; $display("FAIL frame2_col0 got %h exp 41", row_data); end
      end
      if (k == 27) begin
        checks++; if (row_data !== 7'h7F) begin errors++; $display("FAIL frame2_col1 got %h exp 7f", row_data); end
      end
      if (frame_tick === 1'b1 && tick_at == 0) tick_at = k;
    end
    checks++; if (tick_at != 20) begin errors++; $display("FAIL first_tick got clock %0d exp 20", tick_at); end
  endtask

  task automatic test_page_a_only();
    img_b_valid = 1'b0; img_b_col_1 = 7'h03; img_b_col_0 = 7'h0F;
    for (int k = 0; k < 10 * FRAME_CLKS; k++) begin
      @(negedge clk);
      checks++;
      if (col_en !== e_col || row_data !== e_row || page !== e_page || frame_tick !== e_tick) begin
        errors++;
        $display("FAIL a_only k=%0d got col=%b row=%h pg=%b tk=%b exp col=%b row=%h pg=%b tk=%b",
                 k, col_en, row_data, page, frame_tick, e_col, e_row, e_page, e_tick);
      end
      if (page !== 1'b0 || row_data === 7'd0) begin
        checks++; errors++; $display("FAIL a_only_no_blank k=%0d got pg=%b row=%h exp pg=0 row!=0", k, page, row_data);
      end
    end
  endtask

  task automatic test_rotation();
    bit seen_b, seen_blank;
    seen_b = 0; seen_blank = 0;
    img_b_col_1 = 7'h03; img_b_col_0 = 7'h0F; img_b_valid = 1'b1;
    for (int k = 0; k < 12 * FRAME_CLKS; k++) begin
      @(negedge clk);
      checks++;
      if (col_en !== e_col || row_data !== e_row || page !== e_page || frame_tick !== e_tick) begin
        errors++;
        $display("FAIL rotation k=%0d got col=%b row=%h pg=%b tk=%b exp col=%b row=%h pg=%b tk=%b",
                 k, col_en, row_data, page, frame_tick, e_col, e_row, e_page, e_tick);
      end
      if (page === 1'b1) seen_b = 1;
      if (row_data === 7'd0) seen_blank = 1;
    end
    checks++; if (!seen_b) begin errors++; $display("FAIL rotation_page_b got 0 exp 1"); end
    checks++; if (!seen_blank) begin errors++; $display("FAIL rotation_blank got 0 exp 1"); end
  endtask

  task automatic test_valid_drop();
    int n;
    img_b_valid = 1'b1;
    // Align to the first clock of a B frame.
    n = 0;
    while (!(page === 1'b0 && e_kind_is_blank_ab()) && n < 200) begin @(negedge clk); n++; end
    while (page !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL drop_align timeout got %0d exp <200", n); end
    repeat (2 * SD + 1) @(negedge clk);
    img_b_valid = 1'b0;
    n = 0;
    while (frame_tick !== 1'b1 && n < FRAME_CLKS) begin
      checks++; if (page !== 1'b1) begin errors++; $display("FAIL drop_b_completes got pg=%b exp 1", page); end
      @(negedge clk); n++;
    end
    checks++; if (n >= FRAME_CLKS) begin errors++; $display("FAIL drop_tick timeout got %0d", n); end
    for (int k = 0; k < 3 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (k < FRAME_CLKS) begin
        checks++;
        if (page !== 1'b0 || row_data !== 7'd0 || col_en !== 5'd0) begin
          errors++; $display("FAIL drop_blank k=%0d got pg=%b row=%h col=%b exp 0/00/00000", k, page, row_data, col_en);
        end
      end
      checks++;
      if (col_en !== e_col || row_data !== e_row || page !== e_page || frame_tick !== e_tick) begin
        errors++;
        $display("FAIL drop_model k=%0d got col=%b row=%h pg=%b exp col=%b row=%h pg=%b", k, col_en, row_data, page, e_col, e_row, e_page);
      end
    end
  endtask

  function automatic bit e_kind_is_blank_ab();
    return (m_kind == 1);
  endfunction

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if (col_en !== e_col || row_data !== e_row || page !== e_page || frame_tick !== e_tick) begin
        errors++;
        $display("FAIL random k=%0d got col=%b row=%h pg=%b tk=%b exp col=%b row=%h pg=%b tk=%b",
                 k, col_en, row_data, page, frame_tick, e_col, e_row, e_page, e_tick);
      end
      if ($urandom_range(0, 29) == 0) begin
        img_a_col_1 = 7'($urandom); img_a_col_0 = 7'($urandom);
        img_b_col_1 = 7'($urandom); img_b_col_0 = 7'($urandom);
      end
      if ($urandom_range(0, 99) == 0) img_b_valid = ~img_b_valid;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    img_b_valid = 1'b1;
    n = 0;
    while (!(page === 1'b1 && col_en[3] === 1'b1) && n < 300) begin @(negedge clk); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL rst_mid_align timeout got %0d exp <300", n); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (col_en !== 5'd0 || page !== 1'b0 || frame_tick !== 1'b0 || row_data !== 7'd0) begin
      errors++; $display("FAIL rst_mid got col=%b pg=%b tk=%b row=%h exp 00000/0/0/00", col_en, page, frame_tick, row_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3 * FRAME_CLKS; k++) begin
      @(negedge clk);
      checks++;
      if (col_en !== e_col || row_data !== e_row || page !== e_page || frame_tick !== e_tick) begin
        errors++; $display("FAIL rst_restart k=%0d got col=%b row=%h pg=%b exp col=%b row=%h pg=%b", k, col_en, row_data, page, e_col, e_row, e_page);
      end
      if (k < FRAME_CLKS && row_data !== 7'd0) begin
        checks++; errors++; $display("FAIL rst_restart_zero k=%0d got %h exp 00", k, row_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_page_a_only();
    test_rotation();
    test_valid_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
- Drives the CPLD kit's 5x7 LED matrix by column multiplexing.
- Time-shares the matrix between two Y-symmetric image sources, each given as the 2-column encoding (col_1 feeds columns 0 and 4; col_0 feeds columns 1, 2 and 3):
  - page A: water level image, always present;
  - page B: secondary status image, optional and gated by a valid flag.
- Sequences the column scan, rotates pages on frame boundaries and inserts a blank frame at each page switch.
- Sits between the image decoders and the board pin wrapper.

Parameters:
- SCAN_DIV, 1000: clocks per column slot; must be >= 4.
- PAGE_FRAMES, 200: full 5-column frames shown per page before rotating; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- img_a_col_1  input  7  page A pattern for columns 0 and 4.
- img_a_col_0  input  7  page A pattern for columns 1, 2 and 3.
- img_b_col_1  input  7  page B pattern for columns 0 and 4.
- img_b_col_0  input  7  page B pattern for columns 1, 2 and 3.
- img_b_valid  input  1  page B present; while low, only page A is shown.
- col_en  output  5  one-hot column enable; bit n drives column n; all-zero means blank.
- row_data  output  7  row pattern for the enabled column, passed through unchanged (the decoders own polarity).
- page  output  1  0 = page A shown, 1 = page B shown; 0 during blank frames.
- frame_tick  output  1  one-clock pulse on the last clock of every frame.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-high and takes priority over all other events.
- Reset values:
  - Outputs: col_en=0, row_data=0, page=0, frame_tick=0.
  - Internal: div_cnt=0, col_idx=0, frame_cnt=0, state=SHOW_A, frame buffer=0.
- Divider: div_cnt counts 0..SCAN_DIV-1, then wraps to 0. The clock where div_cnt==SCAN_DIV-1 is the slot end.
- Column index: col_idx advances 0,1,2,3,4,0 at each slot end.
- Frame boundary:
  - Defined as a slot end with col_idx==4.
  - frame_tick is registered; it is high during the clock after the boundary edge.
- Frame buffer:
  - The active page's col_1/col_0 pair is captured into the frame buffer at every frame boundary.
  - Input changes mid-frame never tear the displayed image.
  - The first frame after reset displays the reset buffer (all zeros).
- Output registration and latency:
  - col_en and row_data are registered, 1 clock after col_idx/state.
  - Each column is held for exactly SCAN_DIV clocks.
- Column-to-pattern mapping:
  - row_data = buf_col_1 when col_idx is 0 or 4.
  - row_data = buf_col_0 when col_idx is 1, 2 or 3.
- Page state machine:
  - States: SHOW_A, BLANK_AB, SHOW_B, BLANK_BA. Transitions occur only at frame boundaries.
  - SHOW_A: frame_cnt increments per frame. At frame_cnt==PAGE_FRAMES-1 with img_b_valid=1, go to BLANK_AB and clear frame_cnt. If img_b_valid=0, stay in SHOW_A and clear frame_cnt.
  - BLANK_AB: one frame. col_en=0 and row_data=0 for the whole frame. Next state is SHOW_B, with the buffer loaded from page B at that boundary.
  - SHOW_B: page=1. At frame_cnt==PAGE_FRAMES-1, or at any boundary where img_b_valid=0, go to BLANK_BA and clear frame_cnt.
  - BLANK_BA: one blank frame, then SHOW_A.
- Boundary rules:
  - img_b_valid falling mid-frame: the current page B frame completes, then BLANK_BA follows.
  - img_b_valid is sampled only at frame boundaries.
  - Reset mid-frame: all state returns to reset values on the next edge, with no partial column.
  - PAGE_FRAMES=1: each page shows one frame, then blanks.

Optional Feature:
- Macro: MATRIX_SCAN_DEADTIME_EN.
- Defined: col_en is forced to 0 on the first 2 clocks of every column slot (div_cnt<2, seen at the output 1 clock later). row_data still switches immediately. This removes ghosting on column changes; the effective on-time is SCAN_DIV-2 clocks.
- Undefined: no dead time; col_en is continuous.

Test Plan:
- SCAN_DIV=4, PAGE_FRAMES=2; reset held 3 clocks, then released -> col_en=00001 one clock after release. col_en walks 00010, 00100, 01000, 10000 every 4 clocks. row_data=0 during frame 1. frame_tick pulses at clock 20.
- img_a_col_1=7'h41, img_a_col_0=7'h7F, img_b_valid=0 -> from frame 2: row_data is 41,7F,7F,7F,41 across columns 0..4. page stays 0 indefinitely and no blank frames occur.
- img_b_valid=1, img_b_col_1=7'h03, img_b_col_0=7'h0F -> 2 frames of A, 1 frame with col_en=0, 2 frames with page=1 and rows 03,0F,0F,0F,03, 1 blank frame, then A again.
- img_b_valid dropped in column 2 of the first B frame -> that B frame completes, then BLANK_BA, then SHOW_A.
- reset asserted mid-column 3 of SHOW_B -> the next clock shows col_en=0, page=0, frame_tick=0; the sequence restarts as in test 1.
- MATRIX_SCAN_DEADTIME_EN defined, SCAN_DIV=4 -> each column is enabled for 2 of 4 clocks, and col_en=0 on the first 2 clocks of each slot.
